pixel_readout_ctrl: RTL

Digital sequencer and data-bus master for one pixelSensor instance.
- Runs each frame through erase, exposure, ramp ADC conversion and readout.
- During conversion, it clocks the pixel's ramp input and drives the conversion count onto the shared pixData bus; the pixel latches that count when its comparator trips.
- It then releases the bus, asserts pixRead, captures the pixel's 8-bit result and presents it upstream with a valid strobe.

---
 rtl/pixel_ctrl_pkg.sv | 36 +++
 rtl/pixel_readout_ctrl_if.sv | 25 ++
 rtl/pixel_step_timer.sv | 28 ++
 rtl/pixel_readout_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types, widths, default timings and Gray helpers for the pixel readout controller.
package pixel_ctrl_pkg;

    localparam int unsigned PIX_W = 8;
    // Wide enough for the longest phase: 2 * 65535 exposure cycles.
    localparam int unsigned TMR_W = 17;

    localparam int unsigned DEF_ERASE_CYC  = 4;
    localparam int unsigned DEF_EXPO_CYC   = 64;
    localparam int unsigned DEF_CONV_STEPS = 255;
    localparam int unsigned DEF_READ_CYC   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StExpose,
        StConvert,
        StTurn,
        StRead,
        StDone
    } state_e;

    function automatic logic [PIX_W-1:0] bin2gray(input logic [PIX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PIX_W-1:0] gray2bin(input logic [PIX_W-1:0] g);
        logic [PIX_W-1:0] b;
        b[PIX_W-1] = g[PIX_W-1];
        for (int i = PIX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_readout_ctrl_if.sv
// Control and upstream result signals between the readout controller and its neighbours.
interface pixel_readout_ctrl_if;
    import pixel_ctrl_pkg::*;

    logic             start;
    logic             pixErase;
    logic             pixTx;
    logic             anaBias1;
    logic             anaRamp;
    logic             pixRead;
    logic [PIX_W-1:0] data_out;
    logic             data_valid;
    logic             busy;

    modport master (
        input  start,
        output pixErase, pixTx, anaBias1, anaRamp, pixRead, data_out, data_valid, busy
    );

    modport slave (
        output start,
        input  pixErase, pixTx, anaBias1, anaRamp, pixRead, data_out, data_valid, busy
    );

endinterface

// File: rtl/pixel_step_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module pixel_step_timer
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned Width = TMR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer and pixData bus master for one pixel sensor.
// Build option: define GRAY_CODE_EN for a Gray-coded count bus and Gray-decoded capture.
module pixel_readout_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned ERASE_CYC  = DEF_ERASE_CYC,
    parameter int unsigned EXPO_CYC   = DEF_EXPO_CYC,
    parameter int unsigned CONV_STEPS = DEF_CONV_STEPS,
    parameter int unsigned READ_CYC   = DEF_READ_CYC
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pixel_readout_ctrl_if.master    ctrl,
    inout  wire [PIX_W-1:0]         pixData
);

    state_e           state_q;
    logic [PIX_W-1:0] cnt_q;
    logic             bus_oe_q;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic [PIX_W-1:0] bus_val;
    logic [PIX_W-1:0] cap_val;

`ifdef GRAY_CODE_EN
    assign bus_val = bin2gray(cnt_q);
    assign cap_val = gray2bin(pixData);
`else
    assign bus_val = cnt_q;
    assign cap_val = pixData;
`endif

    // Controller drives only in CONVERT; the sensor drives only while pixRead is high.
    assign pixData = bus_oe_q ? bus_val : {PIX_W{1'bz}};

    // Timer is reloaded on the same edge that enters each timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                tmr_load = ctrl.start;
                tmr_val  = TMR_W'(ERASE_CYC - 1);
            end
            StErase: begin
                tmr_load = tmr_done;
                tmr_val  = TMR_W'(2 * EXPO_CYC - 1);
            end
            StExpose: begin
                tmr_load = tmr_done;
                tmr_val  = TMR_W'(2 * CONV_STEPS - 1);
            end
            StTurn: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(READ_CYC - 1);
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    pixel_step_timer #(
        .Width (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Outputs are set on the transition edge so each one is a plain register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            bus_oe_q        <= 1'b0;
            ctrl.pixErase   <= 1'b0;
            ctrl.pixTx      <= 1'b0;
            ctrl.anaBias1   <= 1'b0;
            ctrl.anaRamp    <= 1'b0;
            ctrl.pixRead    <= 1'b0;
            ctrl.data_out   <= '0;
            ctrl.data_valid <= 1'b0;
            ctrl.busy       <= 1'b0;
        end else begin
            ctrl.data_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ctrl.start) begin
                        state_q       <= StErase;
                        ctrl.pixErase <= 1'b1;
                        ctrl.busy     <= 1'b1;
                    end
                end
                StErase: begin
                    if (tmr_done) begin
                        state_q       <= StExpose;
                        ctrl.pixErase <= 1'b0;
                        ctrl.pixTx    <= 1'b1;
                        ctrl.anaBias1 <= 1'b0;
                    end
                end
                StExpose: begin
                    ctrl.anaBias1 <= ~ctrl.anaBias1;
                    if (tmr_done) begin
                        state_q       <= StConvert;
                        ctrl.pixTx    <= 1'b0;
                        ctrl.anaBias1 <= 1'b0;
                        ctrl.anaRamp  <= 1'b0;
                        cnt_q         <= '0;
                        bus_oe_q      <= 1'b1;
                    end
                end
                StConvert: begin
                    ctrl.anaRamp <= ~ctrl.anaRamp;
                    // Count moves in the same cycle the ramp rises and holds at full scale.
                    if (!ctrl.anaRamp && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (tmr_done) begin
                        state_q      <= StTurn;
                        ctrl.anaRamp <= 1'b0;
                        bus_oe_q     <= 1'b0;
                    end
                end
                StTurn: begin
                    state_q      <= StRead;
                    ctrl.pixRead <= 1'b1;
                end
                StRead: begin
                    if (tmr_done) begin
                        state_q         <= StDone;
                        ctrl.pixRead    <= 1'b0;
                        ctrl.data_out   <= cap_val;
                        ctrl.data_valid <= 1'b1;
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    ctrl.busy <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
